alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 20 ++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_op_decode.sv | 25 ++
 rtl/alu_arbiter.sv | 112 +++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM state encoding, the ALU control codes and a grant helper.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, response and shared-ALU signals of the arbiter.
// The arbiter uses the slave view; requesters plus the ALU use the master view.
interface alu_arbiter_if #(parameter int W = 32);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [3:0]     req_aluop;
  logic [1:0]     req_fun7;
  logic [5:0]     req_fun3;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [W-1:0]   rsp_data;
  logic           rsp_zero;
  logic [3:0]     alu_ctrl;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_result;
  logic           alu_zero;

  modport slave (
    input  req_valid, req_aluop, req_fun7, req_fun3, req_a, req_b,
           rsp_ready, alu_result, alu_zero,
    output req_ready, rsp_valid, rsp_data, rsp_zero, alu_ctrl, alu_a, alu_b
  );

  modport master (
    output req_valid, req_aluop, req_fun7, req_fun3, req_a, req_b,
           rsp_ready, alu_result, alu_zero,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, alu_ctrl, alu_a, alu_b
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational decode of {aluop, fun7, fun3} into the 4-bit ALU control code.
// Any code not listed maps to AND.
module alu_op_decode
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic       fun7,
  input  logic [2:0] fun3,
  output logic [3:0] ctrl
);

  always_comb begin
    ctrl = ALU_AND;
    case ({aluop, fun7, fun3})
      6'b00_0_000: ctrl = ALU_ADD;
      6'b01_0_000: ctrl = ALU_SUB;
      6'b10_0_000: ctrl = ALU_ADD;
      6'b10_1_000: ctrl = ALU_SUB;
      6'b10_0_111: ctrl = ALU_AND;
      6'b10_0_110: ctrl = ALU_OR;
      default:     ctrl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation walks IDLE (accept) -> EXEC (capture result) -> RESP (handshake).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  state_e       state_q, state_d;
  logic         gnt_q, gnt_d;
  logic         last_q, last_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic [W-1:0] data_q, data_d;
  logic         zero_q, zero_d;
  logic [1:0]   req_ready_c;
  logic [1:0]   rsp_valid_c;

  // On contention the requester that did not win last time goes next.
  logic         gnt_idx;
  logic [1:0]   sel_aluop;
  logic         sel_fun7;
  logic [2:0]   sel_fun3;
  logic [3:0]   dec_ctrl;

  assign gnt_idx   = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];
  assign sel_aluop = gnt_idx ? bus.req_aluop[3:2] : bus.req_aluop[1:0];
  assign sel_fun7  = gnt_idx ? bus.req_fun7[1]    : bus.req_fun7[0];
  assign sel_fun3  = gnt_idx ? bus.req_fun3[5:3]  : bus.req_fun3[2:0];

  alu_op_decode u_decode (
    .aluop (sel_aluop),
    .fun7  (sel_fun7),
    .fun3  (sel_fun3),
    .ctrl  (dec_ctrl)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    zero_d      = zero_q;
    req_ready_c = 2'b00;
    rsp_valid_c = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c = onehot2(gnt_idx);
          state_d     = ST_EXEC;
          gnt_d       = gnt_idx;
          last_d      = gnt_idx;
          a_d         = gnt_idx ? bus.req_a[2*W-1:W] : bus.req_a[W-1:0];
          b_d         = gnt_idx ? bus.req_b[2*W-1:W] : bus.req_b[W-1:0];
          ctrl_d      = dec_ctrl;
        end
      end
      ST_EXEC: begin
        data_d  = bus.alu_result;
        zero_d  = bus.alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_c = onehot2(gnt_q);
        if (bus.rsp_ready[gnt_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 4'b0000;
      data_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

  // req_ready is combinational, so it is gated to stay low while reset is held.
  assign bus.req_ready = reset ? 2'b00 : req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;

endmodule
